mem_stage: RTL and testbench

//  Memory pipeline stage, directly downstream of exe_stage. Accepts es_to_ms_bus, waits for

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - valid/bus/allowin link between adjacent pipeline stages
//
// Purpose: carries one stage-to-stage payload with its handshake. The producer
//   asserts valid with bus, and the consumer returns allowin. A payload moves
//   on a cycle where valid & allowin.
// Ports (signals):
//   valid    producer -> consumer  payload valid
//   bus      producer -> consumer  payload, WD bits
//   allowin  consumer -> producer  consumer can accept this cycle
// Modports: master = producer side, slave = consumer side.
interface mem_stage_if #(
  parameter int WD = 32
) ();
  logic          valid;
  logic [WD-1:0] bus;
  logic          allowin;

  modport master (output valid, output bus, input allowin);
  modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: waits for data_sram response, aligns load data
//
// Purpose: holds one EXE payload and waits for the data_sram response to the
//   request EXE issued. It then aligns and extends load data and hands the
//   result to WB. A request cancelled by a flush has its late response
//   dropped in the DISCARD state.
// Optional feature macro: MS_LOAD_FWD_EN. When defined, ld_pending drops as
//   soon as load data is present in MEM, so ID can forward it from here.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   es_to_ms  (slave)    valid=es_to_ms_valid, bus=es_to_ms_bus[170:0], allowin=ms_allowin
//   ms_to_ws  (master)   valid=ms_to_ws_valid, bus=ms_to_ws_bus[159:0], allowin=ws_allowin
//   data_sram_data_ok    response strobe, one per accepted request, in order
//   data_sram_rdata      read data, valid with data_ok
//   final_ex             exception committed in WB (flush)
//   back_ertn_flush      ertn committed in WB (flush)
//   ms_ex                ms_valid & ex
//   ms_ertn_flush        ms_valid & ertn
//   ms_forward[57:0]     {csr_re,csr_num,csr_we,ertn,ex,ld_pending,final_result,dest,gr_we,ms_valid}
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 171,
  parameter int MS_TO_WS_BUS_WD = 160
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  es_to_ms,
  mem_stage_if.master ms_to_ws,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        final_ex,
  input  logic        back_ertn_flush,
  output logic        ms_ex,
  output logic        ms_ertn_flush,
  output logic [57:0] ms_forward
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DISCARD} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_ms_valid;
  logic [31:0]                r_buf;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;

  // Fields of the held payload
  logic        w_rdcntid, w_ertn, w_esubcode, w_ex, w_csr_re, w_csr_we;
  logic [5:0]  w_ecode;
  logic [13:0] w_csr_num;
  logic [31:0] w_csr_wvalue, w_csr_wmask, w_result, w_pc;
  logic [1:0]  w_addr_lo;
  logic        w_ld_b, w_ld_bu, w_ld_h, w_ld_hu, w_res_from_mem, w_gr_we;
  logic [4:0]  w_dest;

  assign w_rdcntid      = r_bus[169];
  assign w_ertn         = r_bus[168];
  assign w_esubcode     = r_bus[167];
  assign w_ecode        = r_bus[166:161];
  assign w_ex           = r_bus[160];
  assign w_csr_re       = r_bus[159];
  assign w_csr_num      = r_bus[158:145];
  assign w_csr_wvalue   = r_bus[144:113];
  assign w_csr_wmask    = r_bus[112:81];
  assign w_csr_we       = r_bus[80];
  assign w_addr_lo      = r_bus[79:78];
  assign w_ld_b         = r_bus[76];
  assign w_ld_bu        = r_bus[75];
  assign w_ld_h         = r_bus[74];
  assign w_ld_hu        = r_bus[73];
  assign w_res_from_mem = r_bus[70];
  assign w_gr_we        = r_bus[69];
  assign w_dest         = r_bus[68:64];
  assign w_result       = r_bus[63:32];
  assign w_pc           = r_bus[31:0];

  // Any load/store owns an outstanding request. An excepting op never issued
  // one, so it must not wait.
  logic w_need_data;
  logic w_in_need;
  assign w_need_data = (r_bus[170] | (|r_bus[77:71])) & ~r_bus[160];
  assign w_in_need   = (es_to_ms.bus[170] | (|es_to_ms.bus[77:71])) & ~es_to_ms.bus[160];

  logic w_flush, w_ready_go, w_ms_allowin, w_entry, w_ws_allowin;
  assign w_flush      = final_ex | back_ertn_flush;
  assign w_ws_allowin = ms_to_ws.allowin;
  assign w_ready_go   = ~w_need_data | (r_state == S_DONE) |
                        ((r_state == S_WAIT) & data_sram_data_ok);
  assign w_ms_allowin = (r_state != S_DISCARD) & (~r_ms_valid | (w_ready_go & w_ws_allowin));
  assign w_entry      = es_to_ms.valid & w_ms_allowin;

  assign es_to_ms.allowin = w_ms_allowin;
  assign ms_to_ws.valid   = r_ms_valid & w_ready_go & ~final_ex;

  // State reached when the held op leaves. A memory op entering at the same
  // time already has its request issued: it normally waits for it, but under
  // a flush its response must be dropped.
  state_t w_after;
  always_comb begin
    w_after = S_IDLE;
    if (w_entry && w_in_need) begin
      w_after = w_flush ? S_DISCARD : S_WAIT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_after;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          if (w_flush || w_ws_allowin) w_state_nxt = w_after;
          else                         w_state_nxt = S_DONE;
        end else if (w_flush) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DONE: begin
        if (w_flush || w_ws_allowin) w_state_nxt = w_after;
      end
      S_DISCARD: begin
        if (data_sram_data_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ms_valid <= 1'b0;
      r_buf      <= 32'h0;
      r_bus      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush)           r_ms_valid <= 1'b0;
      else if (w_ms_allowin) r_ms_valid <= es_to_ms.valid;
      if (w_entry) r_bus <= es_to_ms.bus;
      // The response is consumed now but WB is stalled, so keep it until WB accepts.
      if (r_state == S_WAIT && data_sram_data_ok && !w_ws_allowin && !w_flush)
        r_buf <= data_sram_rdata;
    end
  end

  // Load alignment and extension
  logic [31:0] w_word, w_loaded, w_final_result;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_word = (r_state == S_DONE) ? r_buf : data_sram_rdata;
    case (w_addr_lo)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half   = w_addr_lo[1] ? w_word[31:16] : w_word[15:0];
    w_loaded = w_word;
    if (w_ld_b)       w_loaded = {{24{w_byte[7]}}, w_byte};
    else if (w_ld_bu) w_loaded = {24'h0, w_byte};
    else if (w_ld_h)  w_loaded = {{16{w_half[15]}}, w_half};
    else if (w_ld_hu) w_loaded = {16'h0, w_half};
  end
  assign w_final_result = w_res_from_mem ? w_loaded : w_result;

  logic [MS_TO_WS_BUS_WD-1:0] w_ws_bus;
  assign w_ws_bus = {w_rdcntid, w_ertn, w_esubcode, w_ecode, w_ex, w_csr_re, w_csr_num,
                     w_csr_wvalue, w_csr_wmask, w_csr_we, w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_to_ws.bus = w_ws_bus;

  logic w_ld_pending;
`ifdef MS_LOAD_FWD_EN
  assign w_ld_pending = r_ms_valid & w_res_from_mem & ~w_ready_go;
`else
  assign w_ld_pending = r_ms_valid & w_res_from_mem;
`endif

  assign ms_ex         = r_ms_valid & w_ex;
  assign ms_ertn_flush = r_ms_valid & w_ertn;
  assign ms_forward    = {w_csr_re, w_csr_num, w_csr_we, w_ertn, w_ex, w_ld_pending,
                          w_final_result, w_dest, w_gr_we, r_ms_valid};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        data_ok;
  logic [31:0] rdata;
  logic        final_ex;
  logic        back_ertn_flush;
  logic        ms_ex;
  logic        ms_ertn_flush;
  logic [57:0] ms_forward;

  mem_stage_if #(.WD(171)) es_if ();
  mem_stage_if #(.WD(160)) ws_if ();

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms          (es_if),
    .ms_to_ws          (ws_if),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .final_ex          (final_ex),
    .back_ertn_flush   (back_ertn_flush),
    .ms_ex             (ms_ex),
    .ms_ertn_flush     (ms_ertn_flush),
    .ms_forward        (ms_forward)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

`ifdef MS_LOAD_FWD_EN
  localparam logic PEND_AT_DATA = 1'b0;
`else
  localparam logic PEND_AT_DATA = 1'b1;
`endif

  localparam logic [4:0]  LD_W  = 5'b10000;
  localparam logic [4:0]  LD_B  = 5'b01000;
  localparam logic [4:0]  LD_BU = 5'b00100;
  localparam logic [4:0]  LD_H  = 5'b00010;
  localparam logic [4:0]  LD_HU = 5'b00001;
  localparam logic [31:0] PC    = 32'h1c00_0100;

  function automatic logic [170:0] mk(input logic [4:0] ld, input logic [1:0] lo,
                                      input logic rfm, input logic ex, input logic [5:0] ecode,
                                      input logic ertn, input logic [31:0] result,
                                      input logic [4:0] dest);
    logic [170:0] b;
    b          = '0;
    b[168]     = ertn;
    b[166:161] = ecode;
    b[160]     = ex;
    b[79:78]   = lo;
    b[77:73]   = ld;
    b[70]      = rfm;
    b[69]      = 1'b1;
    b[68:64]   = dest;
    b[63:32]   = result;
    b[31:0]    = PC;
    return b;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; es_if.valid = 1'b1; es_if.bus = mk(LD_W, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 5'd1);
    ws_if.allowin = 1'b1; data_ok = 1'b0; rdata = 32'h0; final_ex = 1'b0; back_ertn_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); es_if.valid = 1'b0; #1;
    checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL reset_ws_valid act=%b exp=0", ws_if.valid); end
    checks++; if (es_if.allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin act=%b exp=1", es_if.allowin); end
    checks++; if (ms_ex !== 1'b0 || ms_ertn_flush !== 1'b0) begin failures++; $display("FAIL reset_ex act=%b%b exp=00", ms_ex, ms_ertn_flush); end
    checks++; if (ms_forward[0] !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid act=%b exp=0", ms_forward[0]); end
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL post_reset_ws_valid act=%b exp=0", ws_if.valid); end
  endtask

  task automatic test_ld_byte();
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  ld;
      logic [31:0] exp;
      ld  = (i == 0) ? LD_B : LD_BU;
      exp = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(ld, 2'b11, 1'b1, 1'b0, 6'd0, 1'b0, 32'h3, 5'd4); #1;
      checks++; if (es_if.allowin !== 1'b1) begin failures++; $display("FAIL byte%0d_allowin act=%b exp=1", i, es_if.allowin); end
      @(negedge clk); es_if.valid = 1'b0; #1;
      checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL byte%0d_wait_valid act=%b exp=0", i, ws_if.valid); end
      checks++; if (ms_forward[39] !== 1'b1) begin failures++; $display("FAIL byte%0d_wait_pending act=%b exp=1", i, ms_forward[39]); end
      @(negedge clk); data_ok = 1'b1; rdata = 32'h80AB_CD12; #1;
      checks++; if (ws_if.valid !== 1'b1) begin failures++; $display("FAIL byte%0d_valid act=%b exp=1", i, ws_if.valid); end
      checks++; if (ws_if.bus[63:32] !== exp) begin failures++; $display("FAIL byte%0d_result act=%h exp=%h", i, ws_if.bus[63:32], exp); end
      @(negedge clk); data_ok = 1'b0; rdata = 32'h0; #1;
      checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL byte%0d_after_valid act=%b exp=0", i, ws_if.valid); end
    end
  endtask

  task automatic test_ld_half();
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  ld;
      logic [1:0]  lo;
      logic [31:0] exp;
      ld  = (i == 0) ? LD_H : LD_HU;
      lo  = (i == 0) ? 2'b10 : 2'b00;
      exp = (i == 0) ? 32'h0000_1234 : 32'h0000_8001;
      @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(ld, lo, 1'b1, 1'b0, 6'd0, 1'b0, 32'h8, 5'd5);
      @(negedge clk); es_if.valid = 1'b0; data_ok = 1'b1; rdata = 32'h1234_8001; #1;
      checks++; if (ws_if.valid !== 1'b1) begin failures++; $display("FAIL half%0d_valid act=%b exp=1", i, ws_if.valid); end
      checks++; if (ws_if.bus[63:32] !== exp) begin failures++; $display("FAIL half%0d_result act=%h exp=%h", i, ws_if.bus[63:32], exp); end
      @(negedge clk); data_ok = 1'b0; rdata = 32'h0;
    end
  endtask

  task automatic test_done_hold();
    int xfers;
    xfers = 0;
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(LD_W, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h10, 5'd6);
    @(negedge clk); es_if.valid = 1'b0; ws_if.allowin = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    if (ws_if.valid && ws_if.allowin) xfers++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); data_ok = 1'b0; rdata = 32'h0; #1;
      if (ws_if.valid && ws_if.allowin) xfers++;
      checks++; if (ws_if.bus[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL done%0d_buffer act=%h exp=deadbeef", i, ws_if.bus[63:32]); end
      checks++; if (es_if.allowin !== 1'b0) begin failures++; $display("FAIL done%0d_allowin act=%b exp=0", i, es_if.allowin); end
    end
    @(negedge clk); ws_if.allowin = 1'b1; #1;
    if (ws_if.valid && ws_if.allowin) xfers++;
    checks++; if (ws_if.bus[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL done_release_result act=%h exp=deadbeef", ws_if.bus[63:32]); end
    checks++; if (ws_if.bus[31:0] !== PC) begin failures++; $display("FAIL done_pc act=%h exp=%h", ws_if.bus[31:0], PC); end
    checks++; if (es_if.allowin !== 1'b1) begin failures++; $display("FAIL done_release_allowin act=%b exp=1", es_if.allowin); end
    @(negedge clk); #1;
    if (ws_if.valid && ws_if.allowin) xfers++;
    checks++; if (xfers !== 1) begin failures++; $display("FAIL done_wb_count act=%0d exp=1", xfers); end
  endtask

  task automatic test_discard();
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(LD_W, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h20, 5'd7);
    @(negedge clk); es_if.valid = 1'b0; final_ex = 1'b1; #1;
    checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL discard_flush_valid act=%b exp=0", ws_if.valid); end
    @(negedge clk); final_ex = 1'b0; #1;
    checks++; if (es_if.allowin !== 1'b0) begin failures++; $display("FAIL discard_allowin act=%b exp=0", es_if.allowin); end
    @(negedge clk); data_ok = 1'b1; rdata = 32'h5555_AAAA; #1;
    checks++; if (ws_if.valid !== 1'b0 || es_if.allowin !== 1'b0) begin failures++; $display("FAIL discard_drop act=%b%b exp=00", ws_if.valid, es_if.allowin); end
    @(negedge clk); data_ok = 1'b0; #1;
    checks++; if (es_if.allowin !== 1'b1 || ws_if.valid !== 1'b0) begin failures++; $display("FAIL discard_exit act=%b%b exp=10", es_if.allowin, ws_if.valid); end
  endtask

  task automatic test_ex();
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(LD_W, 2'd3, 1'b0, 1'b1, 6'h09, 1'b0, 32'h1003, 5'd8);
    @(negedge clk); es_if.valid = 1'b0; #1;
    checks++; if (ws_if.valid !== 1'b1) begin failures++; $display("FAIL ex_valid act=%b exp=1", ws_if.valid); end
    checks++; if (ms_ex !== 1'b1) begin failures++; $display("FAIL ex_ms_ex act=%b exp=1", ms_ex); end
    checks++; if (ws_if.bus[63:32] !== 32'h1003) begin failures++; $display("FAIL ex_result act=%h exp=00001003", ws_if.bus[63:32]); end
    checks++; if (ws_if.bus[156:150] !== 7'b0010011) begin failures++; $display("FAIL ex_ecode act=%b exp=0010011", ws_if.bus[156:150]); end
    @(negedge clk); #1;
    checks++; if (ms_ex !== 1'b0) begin failures++; $display("FAIL ex_clear act=%b exp=0", ms_ex); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(5'd0, 2'd0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h55, 5'd3);
    @(negedge clk); es_if.bus = mk(LD_W, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h40, 5'd9); #1;
    checks++; if (ws_if.valid !== 1'b1 || ws_if.bus[63:32] !== 32'h55) begin failures++; $display("FAIL b2b_add act=%b/%h exp=1/00000055", ws_if.valid, ws_if.bus[63:32]); end
    checks++; if (es_if.allowin !== 1'b1 || ms_forward[39] !== 1'b0) begin failures++; $display("FAIL b2b_add_fwd act=%b%b exp=10", es_if.allowin, ms_forward[39]); end
    @(negedge clk); es_if.valid = 1'b0; #1;
    checks++; if (ws_if.valid !== 1'b0 || ms_forward[39] !== 1'b1 || ms_forward[0] !== 1'b1) begin failures++; $display("FAIL b2b_ld_wait act=%b%b%b exp=011", ws_if.valid, ms_forward[39], ms_forward[0]); end
    @(negedge clk); data_ok = 1'b1; rdata = 32'h77; #1;
    checks++; if (ws_if.valid !== 1'b1 || ms_forward[38:7] !== 32'h77) begin failures++; $display("FAIL b2b_ld_data act=%b/%h exp=1/00000077", ws_if.valid, ms_forward[38:7]); end
    checks++; if (ms_forward[39] !== PEND_AT_DATA) begin failures++; $display("FAIL b2b_ld_pending act=%b exp=%b", ms_forward[39], PEND_AT_DATA); end
    @(negedge clk); data_ok = 1'b0; #1;
    checks++; if (ws_if.valid !== 1'b0) begin failures++; $display("FAIL b2b_end act=%b exp=0", ws_if.valid); end
  endtask

  task automatic test_flush_done();
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(LD_W, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h60, 5'd10);
    @(negedge clk); es_if.valid = 1'b0; ws_if.allowin = 1'b0; data_ok = 1'b1; rdata = 32'h1111_2222;
    @(negedge clk); data_ok = 1'b0; back_ertn_flush = 1'b1; #1;
    checks++; if (ws_if.valid !== 1'b1 || ws_if.bus[63:32] !== 32'h1111_2222) begin failures++; $display("FAIL flushdone_hold act=%b/%h exp=1/11112222", ws_if.valid, ws_if.bus[63:32]); end
    @(negedge clk); back_ertn_flush = 1'b0; ws_if.allowin = 1'b1; #1;
    checks++; if (ws_if.valid !== 1'b0 || es_if.allowin !== 1'b1) begin failures++; $display("FAIL flushdone_exit act=%b%b exp=01", ws_if.valid, es_if.allowin); end
  endtask

  task automatic test_ertn();
    @(negedge clk); es_if.valid = 1'b1; es_if.bus = mk(5'd0, 2'd0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0, 5'd0);
    @(negedge clk); es_if.valid = 1'b0; #1;
    checks++; if (ms_ertn_flush !== 1'b1 || ws_if.valid !== 1'b1) begin failures++; $display("FAIL ertn act=%b%b exp=11", ms_ertn_flush, ws_if.valid); end
    @(negedge clk); #1;
    checks++; if (ms_ertn_flush !== 1'b0) begin failures++; $display("FAIL ertn_clear act=%b exp=0", ms_ertn_flush); end
  endtask

  initial begin
    test_reset();
    test_ld_byte();
    test_ld_half();
    test_done_hold();
    test_discard();
    test_ex();
    test_back_to_back();
    test_flush_done();
    test_ertn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
